// File: rtl/nand_toggle_gen.sv
// -----------------------------------------------------------------------------
// nand_toggle_gen
//
// Strobe generator for the NAND pad control bus. Once the PLL is locked and a
// burst is requested, it emits cnt_upto pulses. Each pulse drives vec_active
// for S cycles and then vec_idle for H cycles. S and H are setup_cyc and
// hold_cyc, each clamped to a minimum of 1. In read mode the NAND data bus is
// captured on the last active cycle of every pulse.
//
// Ports
//   clk         PLL clock (single domain)
//   reset       asynchronous, active-high reset
//   enable      burst request, held high for the whole burst
//   locked      PLL lock; bursts start and continue only while high
//   mode        0 = write burst, 1 = read burst
//   cnt_upto    number of pulses in the burst (latched at start)
//   setup_cyc   active-phase length in cycles (latched at start)
//   hold_cyc    idle-phase length in cycles (latched at start)
//   vec_active  live vector driven during the active phase
//   vec_idle    live vector driven at all other times
//   din         NAND data bus, sampled in read mode
//   vec_out     control vector to the pads
//   busy        high while in ACTIVE or HOLD
//   done        burst completed normally; held until enable falls
//   pulse_cnt   pulses completed in the current burst
//   rd_data     last captured read byte
//   rd_valid    one-cycle strobe qualifying rd_data
// -----------------------------------------------------------------------------
module nand_toggle_gen #(
   parameter int VEC_W = 5,
   parameter int CNT_W = 12,
   parameter int DLY_W = 4,
   parameter int DAT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             locked,
   input  logic             mode,
   input  logic [CNT_W-1:0] cnt_upto,
   input  logic [DLY_W-1:0] setup_cyc,
   input  logic [DLY_W-1:0] hold_cyc,
   input  logic [VEC_W-1:0] vec_active,
   input  logic [VEC_W-1:0] vec_idle,
   input  logic [DAT_W-1:0] din,
   output logic [VEC_W-1:0] vec_out,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] pulse_cnt,
   output logic [DAT_W-1:0] rd_data,
   output logic             rd_valid
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACTIVE = 2'd1;
   localparam logic [1:0] ST_HOLD   = 2'd2;
   localparam logic [1:0] ST_DONE   = 2'd3;

   // A programmed length of zero behaves as a length of one.
   function automatic logic [DLY_W-1:0] clamp_min1(input logic [DLY_W-1:0] x);
      return (x == '0) ? DLY_W'(1) : x;
   endfunction

   logic [1:0]       state_q,    state_d;
   logic             sel_act_q,  sel_act_d;
   logic [DLY_W-1:0] dly_q,      dly_d;
   logic [CNT_W-1:0] pcnt_q,     pcnt_d;
   logic [DAT_W-1:0] rd_data_q,  rd_data_d;
   logic             rd_valid_q, rd_valid_d;

   // Burst configuration captured at start; only read while a burst is live.
   logic [CNT_W-1:0] upto_q,     upto_d;
   logic             mode_q,     mode_d;
   logic [DLY_W-1:0] s_q,        s_d;
   logic [DLY_W-1:0] h_q,        h_d;

   logic go;
   assign go = enable && locked;

   always_comb begin
      state_d    = state_q;
      dly_d      = dly_q;
      pcnt_d     = pcnt_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
      upto_d     = upto_q;
      mode_d     = mode_q;
      s_d        = s_q;
      h_d        = h_q;

      case (state_q)
         ST_IDLE: begin
            dly_d  = '0;
            pcnt_d = '0;
            if (go) begin
               upto_d  = cnt_upto;
               mode_d  = mode;
               s_d     = clamp_min1(setup_cyc);
               h_d     = clamp_min1(hold_cyc);
               state_d = (cnt_upto == '0) ? ST_DONE : ST_ACTIVE;
            end
         end

         // Abort takes priority over phase completion so that an aborted
         // pulse neither counts nor issues a read strobe.
         ST_ACTIVE: begin
            if (!go) begin
               state_d = ST_IDLE;
               dly_d   = '0;
               pcnt_d  = '0;
            end else if (dly_q == s_q - DLY_W'(1)) begin
               state_d = ST_HOLD;
               dly_d   = '0;
               pcnt_d  = pcnt_q + CNT_W'(1);
               if (mode_q) begin
                  rd_data_d  = din;
                  rd_valid_d = 1'b1;
               end
            end else begin
               dly_d = dly_q + DLY_W'(1);
            end
         end

         ST_HOLD: begin
            if (!go) begin
               state_d = ST_IDLE;
               dly_d   = '0;
               pcnt_d  = '0;
            end else if (dly_q == h_q - DLY_W'(1)) begin
               dly_d   = '0;
               state_d = (pcnt_q == upto_q) ? ST_DONE : ST_ACTIVE;
            end else begin
               dly_d = dly_q + DLY_W'(1);
            end
         end

         ST_DONE: begin
            if (!enable) begin
               state_d = ST_IDLE;
               pcnt_d  = '0;
            end
         end

         default: begin
            state_d = ST_IDLE;
            dly_d   = '0;
            pcnt_d  = '0;
         end
      endcase

      // Registered select: vec_out follows the live vectors but switches
      // between them exactly on the state boundary.
      sel_act_d = (state_d == ST_ACTIVE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         sel_act_q  <= 1'b0;
         dly_q      <= '0;
         pcnt_q     <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         sel_act_q  <= sel_act_d;
         dly_q      <= dly_d;
         pcnt_q     <= pcnt_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   always_ff @(posedge clk) begin
      upto_q <= upto_d;
      mode_q <= mode_d;
      s_q    <= s_d;
      h_q    <= h_d;
   end

   assign vec_out   = sel_act_q ? vec_active : vec_idle;
   assign busy      = (state_q == ST_ACTIVE) || (state_q == ST_HOLD);
   assign done      = (state_q == ST_DONE);
   assign pulse_cnt = pcnt_q;
   assign rd_data   = rd_data_q;
   assign rd_valid  = rd_valid_q;

endmodule

// File: doc/nand_toggle_gen.md
# nand_toggle_gen

Parametrised strobe generator for the NAND interface. Once the PLL reports lock, it drives a burst of N control-vector pulses with run-time programmable setup (active) and hold (idle) lengths. In read mode it also captures the NAND data bus at the end of each active phase. It sits between the NAND command/data sequencer and the pad-level control bus, in the 200 MHz PLL clock domain.

## Interface
Parameters:
- VEC_W, 5: width of the control vector (CE#/CLE/ALE/WE#/RE# style bundle)
- CNT_W, 12: width of the pulse count and the burst-length input
- DLY_W, 4: width of the setup/hold cycle-count inputs
- DAT_W, 8: width of the NAND data bus captured in read mode

Ports:
- clk, in, 1: PLL output clock; one clock domain only
- reset, in, 1: asynchronous, active-high reset
- enable, in, 1: burst request; level-sensitive and held for the whole burst
- locked, in, 1: PLL lock; bursts start and continue only while it is high
- mode, in, 1: 0 = write burst; 1 = read burst (captures data)
- cnt_upto, in, CNT_W: number of pulses in the burst
- setup_cyc, in, DLY_W: active-phase length in cycles
- hold_cyc, in, DLY_W: idle-phase length in cycles
- vec_active, in, VEC_W: vector driven during the active phase
- vec_idle, in, VEC_W: vector driven at all other times
- din, in, DAT_W: NAND data bus, sampled in read mode
- vec_out, out, VEC_W: control vector to the pads
- busy, out, 1: high in ACTIVE and HOLD
- done, out, 1: burst completed normally
- pulse_cnt, out, CNT_W: number of pulses completed in the current burst
- rd_data, out, DAT_W: last captured read byte
- rd_valid, out, 1: one-cycle strobe qualifying rd_data

## Operation
- States: IDLE, ACTIVE, HOLD, DONE.
- **IDLE**
  - Counters are cleared and done = 0.
  - On enable && locked:
    - latch cnt_upto, mode, S = max(setup_cyc, 1) and H = max(hold_cyc, 1).
    - If the latched cnt_upto = 0, go to DONE (no pulses).
    - Otherwise go to ACTIVE.
- **ACTIVE**
  - vec_out = vec_active.
  - On the S-th ACTIVE cycle, increment pulse_cnt and go to HOLD.
  - In read mode, the same edge registers din into rd_data.
- **HOLD**
  - vec_out = vec_idle.
  - On the H-th HOLD cycle:
    - if pulse_cnt equals the latched cnt_upto, go to DONE;
    - otherwise go to ACTIVE.
- **DONE**
  - done = 1, vec_out = vec_idle, pulse_cnt is held.
  - When enable = 0, go to IDLE and clear done.
- **Abort**
  - enable = 0 or locked = 0 while in ACTIVE or HOLD: go to IDLE on the next edge.
  - vec_out = vec_idle from that cycle on. done is never set, and no further rd_valid is issued.
- **Live vs latched inputs**
  - vec_active and vec_idle are live inputs; vec_out is a registered-select mux of the two.
  - Changes to cnt_upto, setup_cyc, hold_cyc or mode during a burst have no effect.
- **Width rules**
  - All delay counters are DLY_W bits wide and never wrap, because S and H are at most 2^DLY_W − 1.
  - pulse_cnt is CNT_W bits; cnt_upto = 2^CNT_W − 1 completes without overflow.
- **Unused encodings:** go to IDLE.

## Timing
- **Reset values:** state IDLE, vec_out = vec_idle, busy = 0, done = 0, pulse_cnt = 0, rd_data = 0, rd_valid = 0. Reset mid-burst yields these immediately (asynchronously).
- **Start:** enable && locked sampled high in IDLE at edge T gives vec_out = vec_active from cycle T+1.
- **Pulse k (k = 1..N):**
  - active in cycles T+1+(k−1)(S+H) through T+(k−1)(S+H)+S;
  - idle for the next H cycles;
  - pulse period is exactly S+H.
- **pulse_cnt** shows k from the first HOLD cycle of pulse k.
- **Read capture:**
  - rd_data captures din as sampled at the last ACTIVE cycle of each pulse.
  - rd_valid = 1 for exactly the first HOLD cycle of that pulse.
  - rd_valid is always 0 in write mode.
- **done** rises at cycle T+N(S+H)+1 and falls on the cycle after enable is sampled low.
- **Back-to-back bursts:** a new burst needs at least one IDLE cycle (enable low, then high again).

## Test plan
- **Write burst:** mode = 0, cnt_upto = 3, setup = 3, hold = 2, vec_active = 5'h1E, vec_idle = 5'h1F.
  - Expect 3 pulses, each 3 cycles of 1E then 2 cycles of 1F.
  - done rises at T+16; pulse_cnt = 3; rd_valid stays 0.
- **Read burst:** mode = 1, cnt_upto = 4, setup = 2, hold = 1, din = 8'hA0 + pulse index.
  - rd_data = A1, A2, A3, A4, each with a single rd_valid in the first HOLD cycle.
  - done rises at T+13.
- **Zero/minimum config:**
  - cnt_upto = 0: done rises at T+1 with no active cycles.
  - setup = 0, hold = 0, cnt_upto = 2: behaves as S = H = 1, alternating active/idle, done at T+5.
- **Abort:** drop enable during the 2nd ACTIVE cycle of pulse 2 (cnt_upto = 5).
  - vec_out = vec_idle the next cycle; back in IDLE; done stays 0.
  - Repeat with locked dropped during HOLD: same response.
- **Reset mid-burst:** assert reset during HOLD of pulse 3.
  - All outputs take their reset values immediately.
  - After release with enable high and locked high, a fresh burst starts with pulse_cnt counting from 1.
- **Gating and config stability:**
  - enable high with locked low: no activity.
  - Changing cnt_upto 3→7 mid-burst still yields 3 pulses.
  - Holding enable high in DONE keeps done = 1 until enable falls.
